// File: rtl/ifid_queue.sv
// IF/ID instruction queue: buffers fetched {pc, instr} pairs in a circular
// buffer and hands them to decode in order over a valid/ready handshake.
// A flush discards everything queued plus the instruction presented that cycle.
module ifid_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_instr,
    output logic                     if_ready,
    input  logic                     flush,
    output logic                     id_valid,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_instr,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           overflow_q, overflow_d;

    logic           empty, full, push, pop;
    logic [AW-1:0]  rd_idx, wr_idx;

    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];
    assign empty  = (rd_ptr_q == wr_ptr_q);
    assign full   = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

    // Handshake qualifiers. A push into a full queue is still taken when the
    // head leaves in the same cycle (slot frees as it fills); if_ready stays a
    // pure function of state so fetch never sees a combinational path from
    // id_ready.
    always_comb begin
        pop  = ~empty & id_ready & ~flush;
        push = if_valid & ~flush & (~full | pop);
    end

    // Pointer and sticky-overflow next state; flush collapses the queue.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q | (if_valid & full & ~pop & ~flush);
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Storage next state: write the incoming pair at the tail slot.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_idx].pc    = if_pc;
            mem_d[wr_idx].instr = if_instr;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage register; contents are qualified by the pointers so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs: head entry gated to zero when the queue is empty.
    always_comb begin
        if_ready = ~full;
        id_valid = ~empty;
        id_pc    = id_valid ? mem_q[rd_idx].pc    : '0;
        id_instr = id_valid ? mem_q[rd_idx].instr : '0;
        count    = wr_ptr_q - rd_ptr_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: a scoreboard queue holds expected
// {pc, instr} pairs pushed on accepted fetches and is compared on each pop.
module tb_ifid_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc, if_instr;
    logic              if_ready;
    logic              flush;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_instr;
    logic              id_ready;
    logic [1:0]        count;
    logic              overflow;

    int                n_chk  = 0;
    int                n_fail = 0;
    logic [63:0]       sb [$];
    logic              ovf_exp;

    ifid_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return (pc << 4) | 32'h13;
    endfunction

    // Drive one cycle of inputs, update the scoreboard from the reference
    // rules and return what the DUT presented at the head before the edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic fl,
                        input logic rdy, output logic popped,
                        output logic [31:0] gpc, output logic [31:0] gins,
                        output logic [31:0] epc, output logic [31:0] eins);
        logic m_full;
        if_valid = v; if_pc = pc; if_instr = ins_of(pc); flush = fl; id_ready = rdy;
        #1;
        m_full = (sb.size() == DEPTH);
        popped = (sb.size() != 0) && rdy && !fl;
        gpc = id_pc; gins = id_instr;
        epc = 32'hDEAD_BEEF; eins = 32'hDEAD_BEEF;
        if (popped) {epc, eins} = sb.pop_front();
        if (v && !fl && m_full && !popped) ovf_exp = 1'b1;
        if (fl) sb.delete();
        else if (v && (!m_full || popped)) sb.push_back({pc, ins_of(pc)});
        @(posedge clk); #1;
        if_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; if_valid = 1'b1; if_pc = 32'h44; if_instr = 32'h55;
        flush = 1'b0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete(); ovf_exp = 1'b0;
        rst = 1'b0; if_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_chk++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin
            n_fail++; $display("FAIL reset_head got v=%b pc=%h ins=%h want 0/0/0", id_valid, id_pc, id_instr); end
        n_chk++; if (if_ready !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got rdy=%b ovf=%b want 1/0", if_ready, overflow); end
    endtask

    task automatic test_single();
        logic p; logic [31:0] gp, gi, ep, ei;
        step(1'b1, 32'h0, 1'b0, 1'b1, p, gp, gi, ep, ei);
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h13) begin
            n_fail++; $display("FAIL single_head got v=%b pc=%h ins=%h want 1/0/13", id_valid, id_pc, id_instr); end
        n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL single_count1 got %0d want 1", count); end
        step(1'b0, 32'h0, 1'b0, 1'b1, p, gp, gi, ep, ei);
        n_chk++; if (!p || gp !== ep || gi !== ei) begin
            n_fail++; $display("FAIL single_pop got %h/%h want %h/%h", gp, gi, ep, ei); end
        n_chk++; if (count !== 2'd0 || id_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_count0 got %0d v=%b want 0/0", count, id_valid); end
    endtask

    task automatic test_overflow();
        logic p; logic [31:0] gp, gi, ep, ei;
        step(1'b1, 32'h4, 1'b0, 1'b0, p, gp, gi, ep, ei);
        step(1'b1, 32'h8, 1'b0, 1'b0, p, gp, gi, ep, ei);
        n_chk++; if (count !== 2'd2 || if_ready !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_state got cnt=%0d rdy=%b ovf=%b want 2/0/0", count, if_ready, overflow); end
        step(1'b1, 32'h99, 1'b0, 1'b0, p, gp, gi, ep, ei);
        n_chk++; if (overflow !== 1'b1 || overflow !== ovf_exp) begin
            n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        n_chk++; if (count !== 2'd2 || id_pc !== 32'h4) begin
            n_fail++; $display("FAIL ovf_hold got cnt=%0d pc=%h want 2/4", count, id_pc); end
    endtask

    task automatic test_push_pop_full();
        logic p; logic [31:0] gp, gi, ep, ei;
        step(1'b1, 32'hC, 1'b0, 1'b1, p, gp, gi, ep, ei);
        n_chk++; if (!p || gp !== 32'h4 || gp !== ep || gi !== ei) begin
            n_fail++; $display("FAIL pp_pop got %h/%h want %h/%h", gp, gi, ep, ei); end
        n_chk++; if (count !== 2'd2) begin n_fail++; $display("FAIL pp_count got %0d want 2", count); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, p, gp, gi, ep, ei);
            n_chk++; if (!p || gp !== ep || gi !== ei) begin
                n_fail++; $display("FAIL pp_drain%0d got %h/%h want %h/%h", i, gp, gi, ep, ei); end
        end
        n_chk++; if (count !== 2'd0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL pp_end got cnt=%0d ovf=%b want 0/1", count, overflow); end
    endtask

    task automatic test_flush();
        logic p; logic [31:0] gp, gi, ep, ei;
        step(1'b1, 32'h20, 1'b0, 1'b0, p, gp, gi, ep, ei);
        step(1'b1, 32'h24, 1'b0, 1'b0, p, gp, gi, ep, ei);
        step(1'b1, 32'h10, 1'b1, 1'b1, p, gp, gi, ep, ei);
        n_chk++; if (count !== 2'd0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
            n_fail++; $display("FAIL flush_clear got cnt=%0d v=%b pc=%h want 0/0/0", count, id_valid, id_pc); end
        step(1'b1, 32'h80, 1'b0, 1'b0, p, gp, gi, ep, ei);
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h80 || count !== 2'd1) begin
            n_fail++; $display("FAIL flush_target got v=%b pc=%h cnt=%0d want 1/80/1", id_valid, id_pc, count); end
        step(1'b0, 32'h0, 1'b0, 1'b1, p, gp, gi, ep, ei);
        n_chk++; if (!p || gp !== ep || gi !== ei) begin
            n_fail++; $display("FAIL flush_drain got %h/%h want %h/%h", gp, gi, ep, ei); end
    endtask

    task automatic test_stream();
        logic p; logic [31:0] gp, gi, ep, ei;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i * 4), 1'b0, 1'b1, p, gp, gi, ep, ei);
            if (i > 0) begin
                n_chk++; if (!p || gp !== 32'((i - 1) * 4) || gp !== ep || gi !== ei) begin
                    n_fail++; $display("FAIL stream%0d got %h/%h want %h/%h", i, gp, gi, ep, ei); end
            end
            n_chk++; if (count !== 2'd1 || id_valid !== 1'b1) begin
                n_fail++; $display("FAIL stream_cnt%0d got %0d v=%b want 1/1", i, count, id_valid); end
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, p, gp, gi, ep, ei);
        n_chk++; if (!p || gp !== 32'h3C || gi !== ei) begin
            n_fail++; $display("FAIL stream_last got %h/%h want 3c/%h", gp, gi, ei); end
        n_chk++; if (overflow !== 1'b0 || count !== 2'd0 || if_ready !== 1'b1) begin
            n_fail++; $display("FAIL stream_end got ovf=%b cnt=%0d rdy=%b want 0/0/1", overflow, count, if_ready); end
    endtask

    task automatic test_reset_midflight();
        logic p; logic [31:0] gp, gi, ep, ei;
        step(1'b1, 32'h40, 1'b0, 1'b0, p, gp, gi, ep, ei);
        step(1'b1, 32'h44, 1'b0, 1'b0, p, gp, gi, ep, ei);
        step(1'b1, 32'h48, 1'b0, 1'b0, p, gp, gi, ep, ei);
        n_chk++; if (count !== 2'd2 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre got cnt=%0d ovf=%b want 2/1", count, overflow); end
        rst = 1'b1; if_valid = 1'b1; if_pc = 32'h4C; if_instr = ins_of(32'h4C); id_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; if_valid = 1'b0; sb.delete(); ovf_exp = 1'b0;
        n_chk++; if (count !== 2'd0 || id_valid !== 1'b0 || if_ready !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got cnt=%0d v=%b rdy=%b ovf=%b want 0/0/1/0",
                               count, id_valid, if_ready, overflow); end
        n_chk++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
            n_fail++; $display("FAIL mid_head got %h/%h want 0/0", id_pc, id_instr); end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        flush = 1'b0; id_ready = 1'b0; ovf_exp = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_push_pop_full();
        test_flush();
        test_stream();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
